// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - data-memory access stage: req/ack memory port, load/store formatting, pipeline stall
//
// Purpose:
//   Turns the MEM-stage load/store control bits and the ALU address into one
//   req/ack transaction on the data-memory port. It stalls the pipeline while
//   the transaction is outstanding, then presents the formatted load result
//   for one DONE cycle.
//
// Parameters:
//   TIMEOUT_CYCLES   WAIT cycles without ack before a fault (0 = no timeout)
//
// Ports:
//   clk              pipeline clock, rising edge
//   reset            asynchronous active-high reset
//   mem_enable_in    instruction in MEM wants a memory access
//   mem_rw_in        1 = store, 0 = load
//   mem_size_in      1 = byte, 0 = word
//   addr_in          effective byte address
//   store_data_in    store source value
//   dmem_req         transaction request, held until ack/timeout
//   dmem_we          write enable of the current transaction
//   dmem_addr        word-aligned address
//   dmem_be          byte enables
//   dmem_wdata       write data (byte stores replicated on all lanes)
//   dmem_rdata       read data, valid with dmem_ack
//   dmem_ack         transaction complete
//   stall_out        hold upstream stages, bubble into MEM/WB
//   load_data_out    formatted load result
//   access_done_out  one-cycle pulse in DONE
//   mem_fault_out    one-cycle pulse in DONE when the access timed out

module mem_access_unit #(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mem_enable_in,
   input  logic        mem_rw_in,
   input  logic        mem_size_in,
   input  logic [31:0] addr_in,
   input  logic [31:0] store_data_in,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [3:0]  dmem_be,
   output logic [31:0] dmem_wdata,
   input  logic [31:0] dmem_rdata,
   input  logic        dmem_ack,
   output logic        stall_out,
   output logic [31:0] load_data_out,
   output logic        access_done_out,
   output logic        mem_fault_out
);

   localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
   localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic          req_q, req_d;
   logic          we_q, we_d;
   logic [31:0]   addr_q, addr_d;
   logic [3:0]    be_q, be_d;
   logic [31:0]   wdata_q, wdata_d;
   logic [1:0]    off_q, off_d;    // byte offset kept for load formatting
   logic          size_q, size_d;
   logic [31:0]   load_q, load_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          done_q, done_d;
   logic          fault_q, fault_d;
   logic [31:0]   fmt_data;

   // Load formatting: word loads rotate right by the byte offset (ARM
   // unaligned LDR), byte loads zero-extend the addressed little-endian lane.
   always_comb begin
      fmt_data = dmem_rdata;
      if (size_q) begin
         unique case (off_q)
            2'd0:    fmt_data = {24'h0, dmem_rdata[7:0]};
            2'd1:    fmt_data = {24'h0, dmem_rdata[15:8]};
            2'd2:    fmt_data = {24'h0, dmem_rdata[23:16]};
            default: fmt_data = {24'h0, dmem_rdata[31:24]};
         endcase
      end else begin
         unique case (off_q)
            2'd0:    fmt_data = dmem_rdata;
            2'd1:    fmt_data = {dmem_rdata[7:0],  dmem_rdata[31:8]};
            2'd2:    fmt_data = {dmem_rdata[15:0], dmem_rdata[31:16]};
            default: fmt_data = {dmem_rdata[23:0], dmem_rdata[31:24]};
         endcase
      end
   end

   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      we_d    = we_q;
      addr_d  = addr_q;
      be_d    = be_q;
      wdata_d = wdata_q;
      off_d   = off_q;
      size_d  = size_q;
      load_d  = load_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      fault_d = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (mem_enable_in) begin
               req_d  = 1'b1;
               we_d   = mem_rw_in;
               addr_d = {addr_in[31:2], 2'b00};
               off_d  = addr_in[1:0];
               size_d = mem_size_in;
               cnt_d  = '0;
               if (mem_size_in) begin
                  be_d    = 4'b0001 << addr_in[1:0];
                  wdata_d = {4{store_data_in[7:0]}};
               end else begin
                  // misaligned word accesses are simply forced aligned
                  be_d    = 4'hF;
                  wdata_d = store_data_in;
               end
               state_d = S_WAIT;
            end
         end

         S_WAIT: begin
            // ack is checked first so that it wins over a same-edge timeout
            if (dmem_ack) begin
               req_d = 1'b0;
               if (!we_q) begin
                  load_d = fmt_data;
               end
               done_d  = 1'b1;
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
               if (TO_EN && (cnt_q == CNT_LAST)) begin
                  req_d   = 1'b0;
                  load_d  = '0;
                  done_d  = 1'b1;
                  fault_d = 1'b1;
                  state_d = S_DONE;
               end
            end
         end

         S_DONE: begin
            // same instruction is still presenting mem_enable_in; do not restart
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         be_q    <= '0;
         wdata_q <= '0;
         off_q   <= '0;
         size_q  <= 1'b0;
         load_q  <= '0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         be_q    <= be_d;
         wdata_q <= wdata_d;
         off_q   <= off_d;
         size_q  <= size_d;
         load_q  <= load_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
         fault_q <= fault_d;
      end
   end

   assign dmem_req        = req_q;
   assign dmem_we         = we_q;
   assign dmem_addr       = addr_q;
   assign dmem_be         = be_q;
   assign dmem_wdata      = wdata_q;
   assign load_data_out   = load_q;
   assign access_done_out = done_q;
   assign mem_fault_out   = fault_q;

   // stall in the request cycle itself, and for every WAIT cycle; DONE releases
   assign stall_out = ((state_q == S_IDLE) && mem_enable_in) || (state_q == S_WAIT);

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed table-driven bench for mem_access_unit

module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        mem_enable_in;
   logic        mem_rw_in;
   logic        mem_size_in;
   logic [31:0] addr_in;
   logic [31:0] store_data_in;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [3:0]  dmem_be;
   logic [31:0] dmem_wdata;
   logic [31:0] dmem_rdata;
   logic        dmem_ack;
   logic        stall_out;
   logic [31:0] load_data_out;
   logic        access_done_out;
   logic        mem_fault_out;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
      .clk             (clk),
      .reset           (reset),
      .mem_enable_in   (mem_enable_in),
      .mem_rw_in       (mem_rw_in),
      .mem_size_in     (mem_size_in),
      .addr_in         (addr_in),
      .store_data_in   (store_data_in),
      .dmem_req        (dmem_req),
      .dmem_we         (dmem_we),
      .dmem_addr       (dmem_addr),
      .dmem_be         (dmem_be),
      .dmem_wdata      (dmem_wdata),
      .dmem_rdata      (dmem_rdata),
      .dmem_ack        (dmem_ack),
      .stall_out       (stall_out),
      .load_data_out   (load_data_out),
      .access_done_out (access_done_out),
      .mem_fault_out   (mem_fault_out)
   );

   typedef struct {
      logic        rw;
      logic        size;
      logic [31:0] addr;
      logic [31:0] sdata;
      logic [31:0] rdata;
      int          lat;        // cycles in WAIT before ack (1..4)
      logic [31:0] exp_addr;
      logic [3:0]  exp_be;
      logic [31:0] exp_wdata;  // checked for stores only
      logic [31:0] exp_load;   // stores expect the previous load value
   } vec_t;

   localparam int NV = 8;
   vec_t vecs [NV];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{1'b0, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF, 32'h1122_3344, 1, 32'h0000_0100, 4'hF, 32'h0, 32'h1122_3344};
      vecs[1] = '{1'b0, 1'b0, 32'h0000_0102, 32'h0,         32'h1122_3344, 2, 32'h0000_0100, 4'hF, 32'h0, 32'h3344_1122};
      vecs[2] = '{1'b0, 1'b1, 32'h0000_0103, 32'h0,         32'hAABB_CCDD, 1, 32'h0000_0100, 4'h8, 32'h0, 32'h0000_00AA};
      vecs[3] = '{1'b1, 1'b1, 32'h0000_0101, 32'h1234_565A, 32'hFFFF_FFFF, 1, 32'h0000_0100, 4'h2, 32'h5A5A_5A5A, 32'h0000_00AA};
      vecs[4] = '{1'b1, 1'b0, 32'h0000_0207, 32'hCAFE_F00D, 32'h0,         3, 32'h0000_0204, 4'hF, 32'hCAFE_F00D, 32'h0000_00AA};
      vecs[5] = '{1'b0, 1'b1, 32'h0000_0001, 32'h0,         32'h1122_3344, 4, 32'h0000_0000, 4'h2, 32'h0, 32'h0000_0033};
      vecs[6] = '{1'b0, 1'b0, 32'h8000_0003, 32'h0,         32'h1122_3344, 1, 32'h8000_0000, 4'hF, 32'h0, 32'h2233_4411};
      vecs[7] = '{1'b0, 1'b1, 32'h0000_0100, 32'h0,         32'hAABB_CCDD, 1, 32'h0000_0100, 4'h1, 32'h0, 32'h0000_00DD};

      reset = 1'b1;
      mem_enable_in = 1'b0;
      mem_rw_in = 1'b0;
      mem_size_in = 1'b0;
      addr_in = '0;
      store_data_in = '0;
      dmem_rdata = '0;
      dmem_ack = 1'b0;

      // reset state
      #3;
      chk("rst_req",   {31'h0, dmem_req}, 32'h0);
      chk("rst_we",    {31'h0, dmem_we}, 32'h0);
      chk("rst_addr",  dmem_addr, 32'h0);
      chk("rst_be",    {28'h0, dmem_be}, 32'h0);
      chk("rst_wdata", dmem_wdata, 32'h0);
      chk("rst_load",  load_data_out, 32'h0);
      chk("rst_done",  {31'h0, access_done_out}, 32'h0);
      chk("rst_fault", {31'h0, mem_fault_out}, 32'h0);
      chk("rst_stall", {31'h0, stall_out}, 32'h0);
      tick();
      tick();
      reset = 1'b0;

      // non-memory instruction: no stall, no request
      @(negedge clk);
      chk("nomem_stall", {31'h0, stall_out}, 32'h0);
      chk("nomem_req",   {31'h0, dmem_req}, 32'h0);
      tick();

      // table-driven accesses, issued back to back
      for (int i = 0; i < NV; i++) begin
         mem_enable_in = 1'b1;
         mem_rw_in     = vecs[i].rw;
         mem_size_in   = vecs[i].size;
         addr_in       = vecs[i].addr;
         store_data_in = vecs[i].sdata;
         dmem_ack      = 1'b0;
         @(negedge clk);
         chk($sformatf("v%0d_req_stall", i), {31'h0, stall_out}, 32'h1);
         chk($sformatf("v%0d_req_early", i), {31'h0, dmem_req}, 32'h0);
         for (int j = 1; j <= vecs[i].lat; j++) begin
            tick();
            dmem_ack   = (j == vecs[i].lat);
            dmem_rdata = (j == vecs[i].lat) ? vecs[i].rdata : 32'h0BAD_0BAD;
            @(negedge clk);
            chk($sformatf("v%0d_w%0d_req", i, j),   {31'h0, dmem_req}, 32'h1);
            chk($sformatf("v%0d_w%0d_stall", i, j), {31'h0, stall_out}, 32'h1);
            chk($sformatf("v%0d_w%0d_addr", i, j),  dmem_addr, vecs[i].exp_addr);
            chk($sformatf("v%0d_w%0d_be", i, j),    {28'h0, dmem_be}, {28'h0, vecs[i].exp_be});
            chk($sformatf("v%0d_w%0d_we", i, j),    {31'h0, dmem_we}, {31'h0, vecs[i].rw});
            if (vecs[i].rw)
               chk($sformatf("v%0d_w%0d_wdata", i, j), dmem_wdata, vecs[i].exp_wdata);
         end
         tick();
         dmem_ack   = 1'b0;
         dmem_rdata = 32'h0BAD_0BAD;
         @(negedge clk);
         chk($sformatf("v%0d_done", i),  {31'h0, access_done_out}, 32'h1);
         chk($sformatf("v%0d_fault", i), {31'h0, mem_fault_out}, 32'h0);
         chk($sformatf("v%0d_stall", i), {31'h0, stall_out}, 32'h0);
         chk($sformatf("v%0d_req", i),   {31'h0, dmem_req}, 32'h0);
         chk($sformatf("v%0d_load", i),  load_data_out, vecs[i].exp_load);
         tick();
      end

      // idle after the last access: no re-trigger, done pulse gone
      mem_enable_in = 1'b0;
      @(negedge clk);
      chk("post_stall", {31'h0, stall_out}, 32'h0);
      chk("post_req",   {31'h0, dmem_req}, 32'h0);
      chk("post_done",  {31'h0, access_done_out}, 32'h0);
      tick();

      // timeout: 4 WAIT cycles without ack
      mem_enable_in = 1'b1;
      mem_rw_in     = 1'b0;
      mem_size_in   = 1'b0;
      addr_in       = 32'h0000_0300;
      @(negedge clk);
      chk("to_stall0", {31'h0, stall_out}, 32'h1);
      for (int j = 1; j <= 4; j++) begin
         tick();
         @(negedge clk);
         chk($sformatf("to_w%0d_req", j),   {31'h0, dmem_req}, 32'h1);
         chk($sformatf("to_w%0d_fault", j), {31'h0, mem_fault_out}, 32'h0);
         chk($sformatf("to_w%0d_done", j),  {31'h0, access_done_out}, 32'h0);
      end
      tick();
      @(negedge clk);
      chk("to_req",   {31'h0, dmem_req}, 32'h0);
      chk("to_done",  {31'h0, access_done_out}, 32'h1);
      chk("to_fault", {31'h0, mem_fault_out}, 32'h1);
      chk("to_load",  load_data_out, 32'h0);
      chk("to_stall", {31'h0, stall_out}, 32'h0);
      tick();
      mem_enable_in = 1'b0;
      @(negedge clk);
      chk("to_fault_clr", {31'h0, mem_fault_out}, 32'h0);
      chk("to_done_clr",  {31'h0, access_done_out}, 32'h0);
      tick();

      // reset while in WAIT, then a stray ack
      mem_enable_in = 1'b1;
      mem_rw_in     = 1'b1;
      mem_size_in   = 1'b0;
      addr_in       = 32'h0000_0040;
      store_data_in = 32'h1357_9BDF;
      tick();
      @(negedge clk);
      chk("rw_req_before", {31'h0, dmem_req}, 32'h1);
      #1;
      reset = 1'b1;
      mem_enable_in = 1'b0;
      #1;
      chk("rw_req_async",  {31'h0, dmem_req}, 32'h0);
      chk("rw_we_async",   {31'h0, dmem_we}, 32'h0);
      chk("rw_addr_async", dmem_addr, 32'h0);
      chk("rw_stall",      {31'h0, stall_out}, 32'h0);
      tick();
      reset = 1'b0;
      dmem_ack = 1'b1;
      dmem_rdata = 32'hFFFF_FFFF;
      for (int j = 0; j < 2; j++) begin
         @(negedge clk);
         chk($sformatf("rw_stray%0d_req", j),   {31'h0, dmem_req}, 32'h0);
         chk($sformatf("rw_stray%0d_done", j),  {31'h0, access_done_out}, 32'h0);
         chk($sformatf("rw_stray%0d_stall", j), {31'h0, stall_out}, 32'h0);
         tick();
      end
      dmem_ack = 1'b0;

      // FSM is back in IDLE: a fresh byte load behaves normally
      mem_enable_in = 1'b1;
      mem_rw_in     = 1'b0;
      mem_size_in   = 1'b1;
      addr_in       = 32'h0000_0002;
      @(negedge clk);
      chk("rw_new_stall", {31'h0, stall_out}, 32'h1);
      chk("rw_new_req0",  {31'h0, dmem_req}, 32'h0);
      tick();
      dmem_ack   = 1'b1;
      dmem_rdata = 32'h1122_3344;
      @(negedge clk);
      chk("rw_new_req1", {31'h0, dmem_req}, 32'h1);
      chk("rw_new_be",   {28'h0, dmem_be}, 32'h4);
      tick();
      dmem_ack = 1'b0;
      @(negedge clk);
      chk("rw_new_done", {31'h0, access_done_out}, 32'h1);
      chk("rw_new_load", load_data_out, 32'h0000_0022);
      tick();
      mem_enable_in = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
